// File: rtl/battle_turn_ctrl.sv
// Turn-based battle sequencer: player command, enemy delay, damage strobes, win/lose.
// An LFSR that runs every cycle supplies both the player accuracy and the enemy damage roll.
module battle_turn_ctrl #(
    parameter int         ENEMY_DELAY = 8,
    parameter logic [7:0] LFSR_SEED   = 8'hA5
) (
    input  logic       clk_b,
    input  logic       rst_n,
    input  logic       col_e,
    input  logic       boss,
    input  logic       btn_valid,
    input  logic [2:0] btn_code,
    input  logic [6:0] HP_player,
    input  logic [7:0] HP_enemy,
    output logic [7:0] key_in,
    output logic [6:0] player_hit,
    output logic [7:0] enemy_hit,
    output logic       hit_valid,
    output logic       battle_active,
    output logic       win,
    output logic       lose,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        P_WAIT    = 3'd1,
        P_RESOLVE = 3'd2,
        E_WAIT    = 3'd3,
        E_RESOLVE = 3'd4,
        WIN       = 3'd5,
        LOSE      = 3'd6
    } state_t;

    state_t     st, st_nxt;
    logic [7:0] lfsr, lfsr_nxt;
    logic [7:0] cnt;
    logic       boss_r, defend_r;
    logic [3:0] acc;
    logic       atk_hit;
    logic [7:0] atk_dmg;
    logic [6:0] base_dmg, e_dmg;
    logic       cmd_ok;

    assign state = st;

    // Right-shifting Galois form of x^8+x^6+x^5+x^4+1.
    assign lfsr_nxt = {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
    assign acc      = (lfsr[3:0] < 4'd10) ? lfsr[3:0] : lfsr[3:0] - 4'd10;
    assign atk_hit  = ({1'b0, acc} + 5'd1) >= {2'b00, btn_code};
    assign atk_dmg  = {2'b00, btn_code, 3'b000} + {4'b0000, btn_code, 1'b0};
    assign base_dmg = boss_r ? 7'd10 + {3'b000, lfsr[6:4], 1'b0}
                             : 7'd5 + {4'b0000, lfsr[6:4]};
    assign e_dmg    = defend_r ? (base_dmg >> 1) : base_dmg;
    assign cmd_ok   = btn_valid && (btn_code <= 3'd4);

    // NOTE: every output of an always_comb gets a default first so no latch is inferred.
    always_comb begin
        st_nxt = st;
        case (st)
            IDLE:      if (col_e) st_nxt = P_WAIT;
            P_WAIT:    if (cmd_ok) st_nxt = P_RESOLVE;
            P_RESOLVE: st_nxt = (enemy_hit >= HP_enemy) ? WIN : E_WAIT;
            E_WAIT:    if (cnt == 8'd0) st_nxt = E_RESOLVE;
            E_RESOLVE: st_nxt = (player_hit >= HP_player) ? LOSE : P_WAIT;
            WIN, LOSE: if (!col_e) st_nxt = IDLE;
            default:   st_nxt = IDLE;
        endcase
    end

    // NOTE: reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
    always_ff @(posedge clk_b) begin
        if (!rst_n) begin
            st            <= IDLE;
            lfsr          <= LFSR_SEED;
            cnt           <= 8'd0;
            boss_r        <= 1'b0;
            defend_r      <= 1'b0;
            key_in        <= 8'd0;
            player_hit    <= 7'd0;
            enemy_hit     <= 8'd0;
            hit_valid     <= 1'b0;
            battle_active <= 1'b0;
            win           <= 1'b0;
            lose          <= 1'b0;
        end else begin
            lfsr          <= lfsr_nxt;
            st            <= st_nxt;
            battle_active <= (st_nxt != IDLE);
            win           <= (st_nxt == WIN);
            lose          <= (st_nxt == LOSE);
            hit_valid     <= 1'b0;
            player_hit    <= 7'd0;
            enemy_hit     <= 8'd0;

            // Damage is rolled on the edge entering a resolve state so it is visible for that whole cycle.
            case (st)
                IDLE: if (col_e) begin
                    boss_r   <= boss;
                    defend_r <= 1'b0;
                end
                P_WAIT: if (cmd_ok) begin
                    key_in    <= {5'b00000, btn_code};
                    hit_valid <= 1'b1;
                    if (btn_code == 3'd0) defend_r  <= 1'b1;
                    else if (atk_hit)     enemy_hit <= atk_dmg;
                end
                P_RESOLVE: if (st_nxt == E_WAIT) cnt <= 8'(ENEMY_DELAY - 1);
                E_WAIT: begin
                    if (cnt == 8'd0) begin
                        hit_valid  <= 1'b1;
                        player_hit <= e_dmg;
                        defend_r   <= 1'b0;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/battle_turn_ctrl.md
BATTLE_TURN_CTRL -- requirements
Module: battle_turn_ctrl

Interface
REQ-001 The block SHALL have parameter ENEMY_DELAY, default 8, meaning the number of cycles in ENEMY_WAIT (range 1..255).
REQ-002 The block SHALL have parameter LFSR_SEED, default 8'hA5, meaning the LFSR reset value (nonzero).
REQ-003 Port clk_b, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 Port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 Port col_e, input, 1 bit: player/enemy collision; starts a battle.
REQ-006 Port boss, input, 1 bit: the current opponent is the boss; sampled at battle start.
REQ-007 Port btn_valid, input, 1 bit: one-cycle strobe qualifying btn_code.
REQ-008 Port btn_code, input, 3 bits: 0 = defend, 1..4 = attack level, 5..7 = invalid.
REQ-009 Port HP_player, input, 7 bits: current player HP from the HP stage.
REQ-010 Port HP_enemy, input, 8 bits: current enemy HP from the HP stage.
REQ-011 Port key_in, output, 8 bits: registered accepted command, {5'b0, btn_code}.
REQ-012 Port player_hit, output, 7 bits: damage applied to the player; valid with hit_valid.
REQ-013 Port enemy_hit, output, 8 bits: damage applied to the enemy; valid with hit_valid.
REQ-014 Port hit_valid, output, 1 bit: one-cycle damage strobe.
REQ-015 Port battle_active, output, 1 bit: high in every state except IDLE.
REQ-016 Port win, output, 1 bit: high while in WIN.
REQ-017 Port lose, output, 1 bit: high while in LOSE.
REQ-018 Port state, output, 3 bits: the current FSM state encoding.

Function
REQ-019 State encodings SHALL be IDLE=0, P_WAIT=1, P_RESOLVE=2, E_WAIT=3, E_RESOLVE=4, WIN=5, LOSE=6.
REQ-020 The 8-bit Galois LFSR SHALL use x^8+x^6+x^5+x^4+1 and advance every cycle, including in IDLE.
REQ-021 acc SHALL be lfsr[3:0] when that value is below 10, otherwise lfsr[3:0]-10; its range is 0..9.
REQ-022 IDLE->P_WAIT SHALL occur when col_e=1; boss_r SHALL latch boss and defend_r SHALL clear on this edge.
REQ-023 In P_WAIT, btn_valid with btn_code<=4 SHALL latch key_in and move to P_RESOLVE.
REQ-024 In P_WAIT, btn_code 5..7 SHALL be ignored and the state held.
REQ-025 btn_valid SHALL be ignored in every state except P_WAIT.
REQ-026 In P_RESOLVE, attack k SHALL hit iff acc>=k-1; a hit SHALL set enemy_hit=10*k, a miss SHALL set enemy_hit=0.
REQ-027 In P_RESOLVE, player_hit SHALL be 0, hit_valid SHALL be 1 for exactly one cycle, and the miss strobe SHALL still be issued.
REQ-028 In P_RESOLVE, defend (code 0) SHALL give enemy_hit=0 and set defend_r.
REQ-029 From P_RESOLVE, enemy_hit>=HP_enemy (sampled same cycle) SHALL go to WIN; otherwise to E_WAIT with the delay counter loaded to ENEMY_DELAY-1.
REQ-030 E_WAIT SHALL decrement the counter each cycle and go to E_RESOLVE at 0, giving exactly ENEMY_DELAY cycles.
REQ-031 In E_RESOLVE, base damage SHALL be 5+lfsr[6:4] (5..12) when boss_r=0, or 10+2*lfsr[6:4] (10..24) when boss_r=1.
REQ-032 In E_RESOLVE, defend_r=1 SHALL halve base damage (floor), and defend_r SHALL then clear.
REQ-033 In E_RESOLVE, player_hit SHALL be the resulting damage, enemy_hit 0, and hit_valid 1 for one cycle.
REQ-034 From E_RESOLVE, player_hit>=HP_player SHALL go to LOSE; otherwise to P_WAIT.
REQ-035 WIN/LOSE SHALL hold while col_e=1 and return to IDLE on the first cycle col_e=0.
REQ-036 In all states other than P_RESOLVE/E_RESOLVE, hit_valid, player_hit and enemy_hit SHALL be 0.
REQ-037 col_e dropping mid-battle (P_WAIT..E_RESOLVE) SHALL NOT abort the battle.
REQ-038 An HP input of 0 SHALL satisfy the >= kill test for any damage value, including 0.

Reset
REQ-039 rst_n=0 at a clock edge SHALL force IDLE, LFSR=LFSR_SEED, counter=0, boss_r=0, defend_r=0, key_in=0, player_hit=0, enemy_hit=0, hit_valid=0, battle_active=0, win=0, lose=0, state=0.
REQ-040 Reset SHALL take priority over all other inputs, including mid-battle and during a hit_valid cycle.

Verification
REQ-041 Start: reset, col_e=1, HP_enemy=80 -> state=1, battle_active=1 next cycle; no hit_valid.
REQ-042 Attack: btn_code=1 strobed, HP_enemy=80 -> one cycle later hit_valid=1, enemy_hit=10 (always hits); then E_WAIT for exactly 8 cycles; then hit_valid with player_hit in 5..12 and state back to 1.
REQ-043 Kill: HP_enemy=30, attack k=3 hit -> enemy_hit=30, WIN; win stays high until col_e=0, then IDLE.
REQ-044 Defend: boss=1 at start, btn_code=0 -> enemy_hit=0; E_RESOLVE player_hit in 5..12.
REQ-045 Lose: HP_player=3, boss=0 -> E_RESOLVE damage>=5 -> LOSE, lose=1.
REQ-046 Robustness: btn_code=6, btn_valid during E_WAIT, and rst_n=0 in E_WAIT -> ignored, ignored, all outputs zero / IDLE next cycle.
